// File: rtl/pipe_ex_mem_if.sv
// EX/MEM stage bundle: ID/EX operands and control, writeback forwarding inputs, and the registered MEM-side outputs.
interface pipe_ex_mem_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             flush;
    logic [3:0]       aluop_in;
    logic             alusrc_in;
    logic             regwrite_in;
    logic             memtoreg_in;
    logic             memwrite_in;
    logic             memread_in;
    logic [4:0]       ars1_in;
    logic [4:0]       ars2_in;
    logic [4:0]       ard_in;
    logic [WIDTH-1:0] rs1_in;
    logic [WIDTH-1:0] rs2_in;
    logic [WIDTH-1:0] immediate_in;
    logic             wb_regwrite;
    logic [4:0]       wb_ard;
    logic [WIDTH-1:0] wb_data;

    logic             regwrite_out;
    logic             memtoreg_out;
    logic             memwrite_out;
    logic             memread_out;
    logic [4:0]       ard_out;
    logic [WIDTH-1:0] alu_result_out;
    logic [WIDTH-1:0] store_data_out;
    logic             zero_out;

    modport master (
        output stall, flush, aluop_in, alusrc_in, regwrite_in, memtoreg_in,
               memwrite_in, memread_in, ars1_in, ars2_in, ard_in, rs1_in,
               rs2_in, immediate_in, wb_regwrite, wb_ard, wb_data,
        input  regwrite_out, memtoreg_out, memwrite_out, memread_out,
               ard_out, alu_result_out, store_data_out, zero_out
    );

    modport slave (
        input  stall, flush, aluop_in, alusrc_in, regwrite_in, memtoreg_in,
               memwrite_in, memread_in, ars1_in, ars2_in, ard_in, rs1_in,
               rs2_in, immediate_in, wb_regwrite, wb_ard, wb_data,
        output regwrite_out, memtoreg_out, memwrite_out, memread_out,
               ard_out, alu_result_out, store_data_out, zero_out
    );
endinterface

// File: rtl/pipe_ex_mem.sv
// EX stage with operand forwarding and ALU, registered into the EX/MEM boundary.
// Latency 1 cycle; stall holds every output, flush loads a bubble, rst overrides both.
module pipe_ex_mem #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ex_mem_if.slave  bus
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASB = 4'b1010;

    logic             ex_fwd_ok;
    logic             wb_fwd_ok;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_res;

    // A load's EX/MEM value is only an address, so it is never a forwarding source.
    assign ex_fwd_ok = bus.regwrite_out && !bus.memtoreg_out && (bus.ard_out != 5'd0);
    assign wb_fwd_ok = bus.wb_regwrite && (bus.wb_ard != 5'd0);

    always_comb begin
        fwd_a = bus.rs1_in;
        if (ex_fwd_ok && (bus.ard_out == bus.ars1_in))
            fwd_a = bus.alu_result_out;
        else if (wb_fwd_ok && (bus.wb_ard == bus.ars1_in))
            fwd_a = bus.wb_data;
    end

    always_comb begin
        fwd_b = bus.rs2_in;
        if (ex_fwd_ok && (bus.ard_out == bus.ars2_in))
            fwd_b = bus.alu_result_out;
        else if (wb_fwd_ok && (bus.wb_ard == bus.ars2_in))
            fwd_b = bus.wb_data;
    end

    assign op_b  = bus.alusrc_in ? bus.immediate_in : fwd_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (bus.aluop_in)
            OP_ADD:  alu_res = fwd_a + op_b;
            OP_SUB:  alu_res = fwd_a - op_b;
            OP_AND:  alu_res = fwd_a & op_b;
            OP_OR:   alu_res = fwd_a | op_b;
            OP_XOR:  alu_res = fwd_a ^ op_b;
            OP_SLL:  alu_res = fwd_a << shamt;
            OP_SRL:  alu_res = fwd_a >> shamt;
            OP_SRA:  alu_res = $signed(fwd_a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (fwd_a < op_b)};
            OP_PASB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.regwrite_out   <= 1'b0;
            bus.memtoreg_out   <= 1'b0;
            bus.memwrite_out   <= 1'b0;
            bus.memread_out    <= 1'b0;
            bus.ard_out        <= 5'd0;
            bus.alu_result_out <= '0;
            bus.store_data_out <= '0;
            bus.zero_out       <= 1'b1;
        end else if (!bus.stall) begin
            bus.regwrite_out   <= bus.regwrite_in;
            bus.memtoreg_out   <= bus.memtoreg_in;
            bus.memwrite_out   <= bus.memwrite_in;
            bus.memread_out    <= bus.memread_in;
            bus.ard_out        <= bus.ard_in;
            bus.alu_result_out <= alu_res;
            bus.store_data_out <= fwd_b;
            bus.zero_out       <= (alu_res == '0);
        end
    end

endmodule

// File: doc/pipe_ex_mem.md
PIPE_EX_MEM -- requirements
Module: pipe_ex_mem

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; shift amount = low 5 bits of operand B.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 STALL  in  1  hold all EX/MEM outputs.
REQ-006 FLUSH  in  1  load a bubble instead of the incoming instruction.
REQ-007 ALUOP_IN  in  4  ALU operation from ID/EX.
REQ-008 ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN, MEMWRITE_IN, MEMREAD_IN  in  1 each  control from ID/EX.
REQ-009 ARS1_IN, ARS2_IN, ARD_IN  in  5 each  source/destination register addresses.
REQ-010 RS1_IN, RS2_IN, IMMEDIATE_IN  in  WIDTH each  register operands and immediate.
REQ-011 WB_REGWRITE  in  1; WB_ARD  in  5; WB_DATA  in  WIDTH  writeback-stage result for forwarding.
REQ-012 REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT  out  1 each  registered control to MEM.
REQ-013 ARD_OUT  out  5  registered destination address.
REQ-014 ALU_RESULT_OUT  out  WIDTH  registered ALU result / memory address.
REQ-015 STORE_DATA_OUT  out  WIDTH  registered forwarded RS2 value.
REQ-016 ZERO_OUT  out  1  registered (ALU result == 0).

Function
REQ-017 Forwarded A SHALL be: ALU_RESULT_OUT if REGWRITE_OUT=1, MEMTOREG_OUT=0, ARD_OUT!=0, ARD_OUT==ARS1_IN; else WB_DATA if WB_REGWRITE=1, WB_ARD!=0, WB_ARD==ARS1_IN; else RS1_IN.
REQ-018 Forwarded B-reg SHALL use the same priority rule against ARS2_IN/RS2_IN.
REQ-019 Operand B SHALL be IMMEDIATE_IN when ALUSRC_IN=1, else forwarded B-reg.
REQ-020 ALUOP: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT (signed, result 0/1), 1001 SLTU, 1010 pass B; 1011-1111 result 0.
REQ-021 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-022 Latency SHALL be one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-023 STORE_DATA_OUT SHALL capture forwarded B-reg, never IMMEDIATE_IN.
REQ-024 Priority per edge: rst > FLUSH > STALL > normal load.
REQ-025 STALL=1 (FLUSH=0): all outputs SHALL hold; forwarding from held outputs remains active.
REQ-026 FLUSH=1: REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT, MEMREAD_OUT, ARD_OUT SHALL load 0; ALU_RESULT_OUT, STORE_DATA_OUT load 0; ZERO_OUT loads 1.
REQ-027 Load-use hazards are resolved upstream by bubble insertion; this block SHALL NOT forward a value whose MEMTOREG_OUT=1.
REQ-028 Register x0 (address 0) SHALL never be a forwarding source.

Reset
REQ-029 On rst=1 at a rising edge all outputs SHALL load 0 except ZERO_OUT, which loads 1.
REQ-030 rst SHALL override STALL and FLUSH; reset mid-stall clears held state.
REQ-031 Outputs SHALL be defined from the first edge with rst=1; no asynchronous behaviour.

Verification
REQ-032 ADD: RS1=5, RS2=7, no hazards, ALUOP=0000, ALUSRC=0, REGWRITE=1, ARD=3 -> next cycle ALU_RESULT_OUT=12, ARD_OUT=3, REGWRITE_OUT=1, ZERO_OUT=0.
REQ-033 Back-to-back forward: cycle 1 writes x3=12; cycle 2 ARS1=3, RS1=0, RS2=1, SUB -> ALU_RESULT_OUT=11 (EX/MEM wins over WB_ARD=3, WB_DATA=99).
REQ-034 WB forward and x0: ARS2=4, WB_REGWRITE=1, WB_ARD=4, WB_DATA=0x10, store -> STORE_DATA_OUT=0x10; repeat with ARS2=0, WB_ARD=0 -> STORE_DATA_OUT=RS2_IN.
REQ-035 Stall then flush: load ADD result 12, STALL=1 for 2 cycles with new inputs -> outputs hold 12; FLUSH=1 and STALL=1 -> all control 0, ALU_RESULT_OUT=0, ZERO_OUT=1.
REQ-036 Shifts/compare: A=0x80000000, B=4: SRA -> 0xF8000000, SRL -> 0x08000000; SLT A<B -> 1, SLTU -> 0; ALUOP=1111 -> 0, ZERO_OUT=1.
REQ-037 Reset mid-operation: after valid load assert rst with STALL=1 -> all outputs 0, ZERO_OUT=1 next edge.
